// File: rtl/ray_leaf_scheduler_pkg.sv
// Shared types for the leaf scheduler and its hit accumulator.
// Fixed-point numbers are signed Q16.16. Primitive boxes, rays and hit
// records are packed structs so they can travel on ports and in registers.
// NULL_PRIM is an inverted box (min=+inf, max=-inf) that no slab test can hit.

`ifndef AABB_TEST_UNIT_SIZE
`define AABB_TEST_UNIT_SIZE 4
`endif

package ray_leaf_scheduler_pkg;

  localparam int PRIM_IDX_W = 16;
  localparam int LEAF_CNT_W = 8;

  typedef logic signed [31:0] Fixed;

  localparam Fixed FIXED_POS_INF = 32'sh7FFF_FFFF;
  localparam Fixed FIXED_NEG_INF = 32'sh8000_0000;

  function automatic Fixed FixedInf();
    return FIXED_POS_INF;
  endfunction

  // Signed compare: a > b
  function automatic logic Fixed_Greater(input Fixed a, input Fixed b);
    return (a > b);
  endfunction

  typedef struct packed {
    Fixed x;
    Fixed y;
    Fixed z;
  } Vec3;

  typedef struct packed {
    Vec3 Origin;
    Vec3 Dir;
  } Ray;

  typedef struct packed {
    Vec3 Min;
    Vec3 Max;
  } AABB;

  typedef struct packed {
    AABB                   Aabb;
    logic [PRIM_IDX_W-1:0] PI;
  } BVH_Primitive_AABB;

  typedef struct packed {
    logic                  bHit;
    Fixed                  T;
    logic [PRIM_IDX_W-1:0] PI;
  } HitData;

  typedef struct packed {
    Ray                    ray;
    logic [PRIM_IDX_W-1:0] start;
    logic [LEAF_CNT_W-1:0] count;
    logic                  any;
  } LeafQuery;

  typedef enum logic [2:0] {
    SCH_IDLE  = 3'd0,
    SCH_FETCH = 3'd1,
    SCH_WAIT  = 3'd2,
    SCH_TEST  = 3'd3,
    SCH_DONE  = 3'd4
  } ScheduleState;

  localparam BVH_Primitive_AABB NULL_PRIM = '{
    Aabb: '{
      Min: '{x: FIXED_POS_INF, y: FIXED_POS_INF, z: FIXED_POS_INF},
      Max: '{x: FIXED_NEG_INF, y: FIXED_NEG_INF, z: FIXED_NEG_INF}
    },
    PI: {PRIM_IDX_W{1'b0}}
  };

  localparam HitData HIT_MISS = '{bHit: 1'b0, T: FIXED_POS_INF, PI: {PRIM_IDX_W{1'b0}}};

endpackage

// File: rtl/ray_leaf_scheduler_hit_accumulator.sv
// hit_accumulator: holds the best hit seen so far for one leaf query.
// Ports:
//   clk, reset  clock, synchronous active-high reset (accumulator -> miss)
//   clear       start of a new query (accumulator -> miss)
//   update_en   closest-hit fold enable for the current batch result
//   any_set     any-hit mode found a hit: mark hit with T=0
//   hit_in      closest-hit reduction of the current batch
//   acc         registered accumulated result

module hit_accumulator
  import ray_leaf_scheduler_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   update_en,
  input  logic   any_set,
  input  HitData hit_in,
  output HitData acc
);

  HitData acc_r;
  logic   take_s;

  // Strictly nearer hits replace the best; on equal T the earlier batch stays.
  always_comb begin
    take_s = 1'b0;
    if (hit_in.bHit && (!acc_r.bHit || Fixed_Greater(acc_r.T, hit_in.T))) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Best-hit register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_r <= HIT_MISS;
    end else if (any_set) begin
      acc_r <= '{bHit: 1'b1, T: 32'sh0000_0000, PI: hit_in.PI};
    end else if (update_en && take_s) begin
      acc_r <= hit_in;
    end
  end

  assign acc = acc_r;

endmodule

// File: rtl/ray_leaf_scheduler.sv
// ray_leaf_scheduler: walks one BVH leaf in batches of AABB_WIDTH primitives.
// For each batch it requests memory, registers the returned primitives onto
// the lanes for one TEST cycle, and folds the lane result into a running hit
// (closest mode) or stops on the first hit (any mode).
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_*                           leaf query from traversal (valid/ready)
//   mem_req_valid/ready/addr        batch fetch request
//   mem_rsp_valid/prim              one-cycle batch response
//   test_ray, test_prim             registered lane inputs
//   test_hit, test_any              combinational lane reductions
//   res_valid/ready, res_hit        final result (valid/ready)
// IDX_W and CNT_W must match the package index/count widths.

module ray_leaf_scheduler
  import ray_leaf_scheduler_pkg::*;
#(
  parameter int AABB_WIDTH = `AABB_TEST_UNIT_SIZE,
  parameter int IDX_W      = PRIM_IDX_W,
  parameter int CNT_W      = LEAF_CNT_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  Ray                                  req_ray,
  input  logic [IDX_W-1:0]                    req_start,
  input  logic [CNT_W-1:0]                    req_count,
  input  logic                                req_any,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [IDX_W-1:0]                    mem_req_addr,
  input  logic                                mem_rsp_valid,
  input  BVH_Primitive_AABB [AABB_WIDTH-1:0]  mem_rsp_prim,
  output Ray                                  test_ray,
  output BVH_Primitive_AABB [AABB_WIDTH-1:0]  test_prim,
  input  HitData                              test_hit,
  input  logic                                test_any,
  output logic                                res_valid,
  input  logic                                res_ready,
  output HitData                              res_hit
);

  localparam logic [IDX_W-1:0] BATCH_IDX = IDX_W'(AABB_WIDTH);
  localparam logic [CNT_W-1:0] BATCH_CNT = CNT_W'(AABB_WIDTH);

  ScheduleState                       state_r;
  logic                               req_ready_r;
  logic                               mem_req_valid_r;
  logic                               res_valid_r;
  // start/count fields track the next fetch index and remaining primitives
  LeafQuery                           query_r;
  BVH_Primitive_AABB [AABB_WIDTH-1:0] test_prim_r;
  HitData                             acc_s;

  logic             accept_s;
  logic             rsp_take_s;
  logic             in_test_s;
  logic             early_exit_s;
  logic [CNT_W-1:0] remaining_next_s;

  assign accept_s     = req_valid && req_ready_r && !reset;
  assign rsp_take_s   = (state_r == SCH_WAIT) && mem_rsp_valid && !reset;
  assign in_test_s    = (state_r == SCH_TEST) && !reset;
  assign early_exit_s = in_test_s && query_r.any && test_any;

  // Remaining count after the current batch, saturating at zero.
  always_comb begin
    remaining_next_s = {CNT_W{1'b0}};
    if (query_r.count > BATCH_CNT) begin
      remaining_next_s = query_r.count - BATCH_CNT;
    end else begin
      remaining_next_s = {CNT_W{1'b0}};
    end
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= SCH_IDLE;
      req_ready_r     <= 1'b0;
      mem_req_valid_r <= 1'b0;
      res_valid_r     <= 1'b0;
    end else begin
      case (state_r)
        SCH_IDLE: begin
          if (accept_s) begin
            req_ready_r <= 1'b0;
            if (req_count == {CNT_W{1'b0}}) begin
              state_r <= SCH_DONE;
            end else begin
              state_r         <= SCH_FETCH;
              mem_req_valid_r <= 1'b1;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        SCH_FETCH: begin
          if (mem_req_ready) begin
            mem_req_valid_r <= 1'b0;
            state_r         <= SCH_WAIT;
          end
        end
        SCH_WAIT: begin
          if (mem_rsp_valid) begin
            state_r <= SCH_TEST;
          end
        end
        SCH_TEST: begin
          if (early_exit_s || (remaining_next_s == {CNT_W{1'b0}})) begin
            state_r <= SCH_DONE;
          end else begin
            state_r         <= SCH_FETCH;
            mem_req_valid_r <= 1'b1;
          end
        end
        SCH_DONE: begin
          // One settling cycle in DONE before the result is presented.
          if (!res_valid_r) begin
            res_valid_r <= 1'b1;
          end else if (res_ready) begin
            res_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            state_r     <= SCH_IDLE;
          end
        end
        default: begin
          state_r         <= SCH_IDLE;
          req_ready_r     <= 1'b0;
          mem_req_valid_r <= 1'b0;
          res_valid_r     <= 1'b0;
        end
      endcase
    end
  end

  // Query registers and lane batch; lanes past the remaining count get NULL_PRIM.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      query_r <= '{ray: req_ray, start: req_start, count: req_count, any: req_any};
    end else if (in_test_s) begin
      query_r.start <= query_r.start + BATCH_IDX;
      query_r.count <= remaining_next_s;
    end
    if (rsp_take_s) begin
      for (int i = 0; i < AABB_WIDTH; i++) begin
        test_prim_r[i] <= (i < int'(query_r.count)) ? mem_rsp_prim[i] : NULL_PRIM;
      end
    end
  end

  hit_accumulator u_acc (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept_s),
    .update_en (in_test_s && !query_r.any),
    .any_set   (early_exit_s),
    .hit_in    (test_hit),
    .acc       (acc_s)
  );

  assign req_ready     = req_ready_r;
  assign mem_req_valid = mem_req_valid_r;
  assign mem_req_addr  = query_r.start;
  assign test_ray      = query_r.ray;
  assign test_prim     = test_prim_r;
  assign res_valid     = res_valid_r;
  assign res_hit       = acc_s;

endmodule

// File: tb/tb_ray_leaf_scheduler.sv
// Bench for ray_leaf_scheduler: memory responder, lane model and result
// scoreboard driven from one linear sequence of directed queries.

module tb_ray_leaf_scheduler;
  import ray_leaf_scheduler_pkg::*;

  localparam int   W   = 4;
  localparam Fixed ONE = 32'sh0001_0000;

  logic                      clk;
  logic                      reset;
  logic                      req_valid;
  logic                      req_ready;
  Ray                        req_ray;
  logic [15:0]               req_start;
  logic [7:0]                req_count;
  logic                      req_any;
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [15:0]               mem_req_addr;
  logic                      mem_rsp_valid;
  BVH_Primitive_AABB [W-1:0] mem_rsp_prim;
  Ray                        test_ray;
  BVH_Primitive_AABB [W-1:0] test_prim;
  HitData                    test_hit;
  logic                      test_any;
  logic                      res_valid;
  logic                      res_ready;
  HitData                    res_hit;

  int checks = 0;
  int errors = 0;

  logic        hit_en [64];
  Fixed        hit_t  [64];
  logic [15:0] addr_q [$];
  HitData      res_q  [$];
  Ray          base_ray;

  ray_leaf_scheduler #(.AABB_WIDTH(W), .IDX_W(16), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_ray       (req_ray),
    .req_start     (req_start),
    .req_count     (req_count),
    .req_any       (req_any),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_prim  (mem_rsp_prim),
    .test_ray      (test_ray),
    .test_prim     (test_prim),
    .test_hit      (test_hit),
    .test_any      (test_any),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_hit       (res_hit)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lane model: a lane hits if its box is non-inverted and its primitive is
  // marked in the hit table; nearest wins, lower lane wins ties.
  always_comb begin
    test_hit = '{bHit: 1'b0, T: 32'sh7FFF_FFFF, PI: 16'h0000};
    test_any = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (($signed(test_prim[i].Aabb.Min.x) <= $signed(test_prim[i].Aabb.Max.x)) &&
          hit_en[test_prim[i].PI[5:0]]) begin
        test_any = 1'b1;
        if (!test_hit.bHit || ($signed(hit_t[test_prim[i].PI[5:0]]) < $signed(test_hit.T))) begin
          test_hit = '{bHit: 1'b1, T: hit_t[test_prim[i].PI[5:0]], PI: test_prim[i].PI};
        end
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  function automatic BVH_Primitive_AABB make_prim(input logic [15:0] pi);
    BVH_Primitive_AABB p;
    p.Aabb.Min = '{x: 32'sh0, y: 32'sh0, z: 32'sh0};
    p.Aabb.Max = '{x: ONE, y: ONE, z: ONE};
    p.PI       = pi;
    return p;
  endfunction

  function automatic BVH_Primitive_AABB null_prim();
    BVH_Primitive_AABB p;
    p.Aabb.Min = '{x: 32'sh7FFF_FFFF, y: 32'sh7FFF_FFFF, z: 32'sh7FFF_FFFF};
    p.Aabb.Max = '{x: 32'sh8000_0000, y: 32'sh8000_0000, z: 32'sh8000_0000};
    p.PI       = 16'h0000;
    return p;
  endfunction

  task automatic clear_hits();
    for (int i = 0; i < 64; i++) begin
      hit_en[i] = 1'b0;
      hit_t[i]  = 32'sh0;
    end
  endtask

  task automatic set_hit(input int pi, input Fixed t);
    hit_en[pi] = 1'b1;
    hit_t[pi]  = t;
  endtask

  // Issue one query, serve memory, check lanes and the result against the
  // scoreboard, then confirm the scheduler goes quiet.
  task automatic run_query(input logic [15:0] start, input logic [7:0] count, input logic any,
                           input int mem_stall, input int res_stall, input int exp_latency);
    HitData      want;
    HitData      cur;
    int          nfetch;
    int          k;
    int          guard;
    int          cyc;
    int          mem_wait;
    int          res_wait;
    int          rsp_batch;
    int          fetches;
    int          test_rem;
    int          stall_left;
    logic        found;
    logic        rsp_pending;
    logic        test_next;
    logic        done;
    logic        saw_res;
    logic [15:0] pi;
    logic [15:0] rsp_addr;
    logic [15:0] test_addr;

    // Reference result and expected fetch addresses.
    want   = '{bHit: 1'b0, T: 32'sh7FFF_FFFF, PI: 16'h0000};
    nfetch = 0;
    found  = 1'b0;
    for (int b = 0; (b * W < int'(count)) && !found; b++) begin
      addr_q.push_back(start + 16'(b * W));
      nfetch++;
      for (int l = 0; l < W; l++) begin
        k = b * W + l;
        if (k < int'(count)) begin
          pi = start + 16'(k);
          if (hit_en[pi[5:0]]) begin
            if (any) begin
              found = 1'b1;
            end else if (!want.bHit || ($signed(hit_t[pi[5:0]]) < $signed(want.T))) begin
              want = '{bHit: 1'b1, T: hit_t[pi[5:0]], PI: pi};
            end
          end
        end
      end
    end
    if (any && found) want = '{bHit: 1'b1, T: 32'sh0, PI: 16'h0000};
    res_q.push_back(want);

    @(negedge clk);
    req_valid = 1'b1;
    req_start = start;
    req_count = count;
    req_any   = any;
    req_ray   = base_ray;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_accept", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);

    cyc = 1; mem_wait = 0; res_wait = 0; rsp_batch = 0; fetches = 0; test_rem = 0;
    stall_left = mem_stall;
    rsp_pending = 1'b0; test_next = 1'b0; done = 1'b0; saw_res = 1'b0;
    rsp_addr = 16'h0; test_addr = 16'h0;
    while (!done && cyc < 200) begin
      mem_rsp_valid = 1'b0;
      if (test_next) begin
        for (int l = 0; l < W; l++) begin
          if (l < test_rem) check("lane_pi", test_prim[l].PI, test_addr + 16'(l));
          else check("lane_null", test_prim[l], null_prim());
        end
        check("test_ray", test_ray, base_ray);
        test_next = 1'b0;
      end
      if (rsp_pending) begin
        mem_rsp_valid = 1'b1;
        for (int l = 0; l < W; l++) mem_rsp_prim[l] = make_prim(rsp_addr + 16'(l));
        test_addr   = rsp_addr;
        test_rem    = int'(count) - rsp_batch * W;
        rsp_batch++;
        rsp_pending = 1'b0;
        test_next   = 1'b1;
      end
      if (mem_req_valid) begin
        if (addr_q.size() == 0) check("extra_fetch", mem_req_valid, 1'b0);
        else check("fetch_addr", mem_req_addr, addr_q[0]);
        if (mem_wait < stall_left) begin
          mem_req_ready = 1'b0;
          mem_wait++;
        end else begin
          mem_req_ready = 1'b1;
          rsp_pending   = 1'b1;
          rsp_addr      = mem_req_addr;
          fetches++;
          stall_left = 0;
          mem_wait   = 0;
          if (addr_q.size() > 0) void'(addr_q.pop_front());
        end
      end else begin
        mem_req_ready = 1'b0;
      end
      if (res_valid) begin
        cur = res_q[0];
        if (!saw_res) begin
          saw_res = 1'b1;
          check("latency", cyc, exp_latency);
        end
        check("res_bhit", res_hit.bHit, cur.bHit);
        check("res_t", res_hit.T, cur.T);
        if (!any) check("res_pi", res_hit.PI, cur.PI);
        check("req_ready_busy", req_ready, 1'b0);
        if (res_wait < res_stall) begin
          res_ready = 1'b0;
          res_wait++;
        end else begin
          res_ready = 1'b1;
          done      = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    res_ready     = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    check("result_seen", done, 1'b1);
    check("req_ready_after", req_ready, 1'b1);
    check("res_valid_after", res_valid, 1'b0);
    check("fetch_count", fetches, nfetch);
    check("fetches_left", addr_q.size(), 0);
    if (res_q.size() > 0) void'(res_q.pop_front());
    addr_q.delete();
    for (int i = 0; i < 3; i++) begin
      check("idle_no_fetch", mem_req_valid, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_ray       = '0;
    req_start     = 16'h0;
    req_count     = 8'h0;
    req_any       = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_prim  = '0;
    res_ready     = 1'b0;
    base_ray      = '{Origin: '{x: ONE, y: 32'sh0002_0000, z: 32'sh0}, Dir: '{x: ONE, y: 32'sh0, z: 32'sh0}};
    clear_hits();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_mem_valid", mem_req_valid, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_bhit", res_hit.bHit, 1'b0);
    check("rst_t", res_hit.T, 32'sh7FFF_FFFF);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    // Zero-count leaf: no fetch, miss after 2 cycles
    clear_hits();
    run_query(16'd5, 8'd0, 1'b0, 0, 0, 2);

    // Partial second batch with a decoy hit in a masked lane
    clear_hits();
    set_hit(11, 32'sh0005_0000);
    set_hit(16, ONE);
    run_query(16'd10, 8'd6, 1'b0, 0, 0, 8);

    // Closest across three batches with an equal-T tie
    clear_hits();
    set_hit(1, 32'sh0003_0000);
    set_hit(2, 32'sh0004_0000);
    set_hit(6, 32'sh0002_0000);
    set_hit(9, 32'sh0002_0000);
    run_query(16'd0, 8'd12, 1'b0, 0, 0, 11);

    // Any-hit early exit after the first batch
    clear_hits();
    set_hit(21, 32'sh0007_0000);
    set_hit(30, ONE);
    run_query(16'd20, 8'd12, 1'b1, 0, 0, 5);

    // Any-hit query with no hit runs every batch
    clear_hits();
    run_query(16'd0, 8'd5, 1'b1, 0, 0, 8);

    // Memory and result backpressure
    clear_hits();
    set_hit(42, 32'sh0001_8000);
    run_query(16'd40, 8'd4, 1'b0, 5, 4, 10);

    // Reset while waiting for memory, with responses during and after reset
    clear_hits();
    set_hit(49, 32'sh0002_8000);
    @(negedge clk);
    req_valid = 1'b1;
    req_start = 16'd48;
    req_count = 8'd4;
    req_any   = 1'b0;
    req_ray   = base_ray;
    check("mid_rst_ready", req_ready, 1'b1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_fetch", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 1'b0);
    check("mid_rst_mem_valid", mem_req_valid, 1'b0);
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_bhit", res_hit.bHit, 1'b0);
    check("mid_rst_t", res_hit.T, 32'sh7FFF_FFFF);
    mem_rsp_valid = 1'b1;
    for (int l = 0; l < W; l++) mem_rsp_prim[l] = make_prim(16'd48 + 16'(l));
    @(negedge clk);
    reset         = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    check("late_rsp_ready", req_ready, 1'b1);
    check("late_rsp_mem_valid", mem_req_valid, 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_rsp_res_valid", res_valid, 1'b0);
      check("late_rsp_bhit", res_hit.bHit, 1'b0);
      check("late_rsp_idle_ready", req_ready, 1'b1);
      @(negedge clk);
    end
    run_query(16'd48, 8'd4, 1'b0, 0, 0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
